icarus_work_sender: RTL and testbench

Host-side end of the Icarus serial protocol. The miner receives work on RxD and returns nonces on TxD; this block drives the miner's RxD and listens on its TxD. It takes one parallel work packet, serializes it as UART 8N1, then collects the 4-byte golden-nonce reply or times out. It is used as the stimulus/response agent in miner top-level benches and in the FPGA loopback self-test harness.

---
 rtl/icarus_pkg.sv | 24 ++
 rtl/icarus_uart_rx.sv | 128 ++++++++++++
 rtl/icarus_work_sender.sv | 182 ++++++++++++++++++
 tb/tb_icarus_work_sender.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icarus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icarus_pkg : shared constants, helpers and encodings for the sender   |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package icarus_pkg;

  localparam int NONCE_BYTES     = 4;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_START = 3'd1,
    ST_TX_DATA  = 3'd2,
    ST_TX_STOP  = 3'd3,
    ST_RX_WAIT  = 3'd4
  } tx_state_t;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icarus_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icarus_uart_rx : free-running 8N1 receiver with byte strobe/frame err |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module icarus_uart_rx
  import icarus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int              c_CW        = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0] c_FULL_LAST = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      c_LAST_BIT  = 3'(UART_FRAME_BITS - 3);

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  rx_state_t       r_state, w_state_nxt;
  logic [1:0]      r_sync;
  logic            r_rx_prev;
  logic [c_CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_err, w_err_nxt;
  logic            w_rx, w_fall, w_full;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_prev & ~w_rx;
  assign w_full = (r_cnt == c_FULL_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_rxd};
      r_rx_prev <= w_rx;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        // Re-check half a bit in; a short glitch is back high by now.
        if (r_cnt == c_HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (w_full) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          if (r_bit == c_LAST_BIT) w_state_nxt = RX_STOP;
          else                     w_bit_nxt   = r_bit + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (w_full) begin
          w_cnt_nxt = '0;
          if (w_rx) begin
            w_valid_nxt = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = RX_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (w_rx) w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign o_data      = r_shift;
  assign o_valid     = r_valid;
  assign o_frame_err = r_err;

endmodule
`default_nettype wire

// File: rtl/icarus_work_sender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icarus_work_sender : serializes one work packet, collects the nonce   |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module icarus_work_sender
  import icarus_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD),
  parameter int WORK_BYTES   = 64,
  parameter int TIMEOUT_CLKS = 100000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*WORK_BYTES-1:0] work_data,
  input  logic                    work_valid,
  output logic                    work_ready,
  output logic                    txd,
  input  logic                    rxd,
  output logic [31:0]             nonce,
  output logic                    nonce_valid,
  output logic                    timeout,
  output logic                    busy
);

  localparam int               c_CW        = $clog2(CLKS_PER_BIT);
  localparam int               c_BCW       = (WORK_BYTES > 1) ? $clog2(WORK_BYTES) : 1;
  localparam int               c_TOW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [c_CW-1:0]  c_CPB_LAST  = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_BCW-1:0] c_BYTE_LAST = c_BCW'(WORK_BYTES - 1);
  localparam logic [c_TOW-1:0] c_TO_LAST   = c_TOW'(TIMEOUT_CLKS - 1);
  localparam logic [2:0]       c_BIT_LAST  = 3'(UART_FRAME_BITS - 3);
  localparam logic [1:0]       c_NB_LAST   = 2'(NONCE_BYTES - 1);

  tx_state_t               r_state, w_state_nxt;
  logic [8*WORK_BYTES-1:0] r_shift, w_shift_nxt;
  logic [c_CW-1:0]         r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]              r_bit_idx, w_bit_idx_nxt;
  logic [c_BCW-1:0]        r_byte_cnt, w_byte_cnt_nxt;
  logic [c_TOW-1:0]        r_to_cnt, w_to_cnt_nxt;
  logic [1:0]              r_rx_cnt, w_rx_cnt_nxt;
  logic [23:0]             r_asm, w_asm_nxt;
  logic [31:0]             r_nonce, w_nonce_nxt;
  logic                    r_nonce_valid, w_nonce_valid_nxt;
  logic                    r_timeout, w_timeout_nxt;
  logic                    w_bit_end;
  logic [7:0]              w_rx_data;
  logic                    w_rx_valid, w_rx_frame_err;

  icarus_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_rxd       (rxd),
    .o_data      (w_rx_data),
    .o_valid     (w_rx_valid),
    .o_frame_err (w_rx_frame_err)
  );

  assign w_bit_end = (r_clk_cnt == c_CPB_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_byte_cnt    <= '0;
      r_to_cnt      <= '0;
      r_rx_cnt      <= '0;
      r_asm         <= '0;
      r_nonce       <= '0;
      r_nonce_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_clk_cnt     <= w_clk_cnt_nxt;
      r_bit_idx     <= w_bit_idx_nxt;
      r_byte_cnt    <= w_byte_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_rx_cnt      <= w_rx_cnt_nxt;
      r_asm         <= w_asm_nxt;
      r_nonce       <= w_nonce_nxt;
      r_nonce_valid <= w_nonce_valid_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_clk_cnt_nxt     = r_clk_cnt;
    w_bit_idx_nxt     = r_bit_idx;
    w_byte_cnt_nxt    = r_byte_cnt;
    w_to_cnt_nxt      = r_to_cnt;
    w_rx_cnt_nxt      = r_rx_cnt;
    w_asm_nxt         = r_asm;
    w_nonce_nxt       = r_nonce;
    w_nonce_valid_nxt = 1'b0;
    w_timeout_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (work_valid) begin
          w_shift_nxt    = work_data;
          w_clk_cnt_nxt  = '0;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = ST_TX_START;
        end
      end
      ST_TX_START: begin
        w_clk_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + 1'b1;
        if (w_bit_end) begin
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_TX_DATA;
        end
      end
      ST_TX_DATA: begin
        w_clk_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + 1'b1;
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[8*WORK_BYTES-1:1]};
          if (r_bit_idx == c_BIT_LAST) w_state_nxt   = ST_TX_STOP;
          else                         w_bit_idx_nxt = r_bit_idx + 1'b1;
        end
      end
      ST_TX_STOP: begin
        w_clk_cnt_nxt = w_bit_end ? '0 : r_clk_cnt + 1'b1;
        if (w_bit_end) begin
          if (r_byte_cnt == c_BYTE_LAST) begin
            w_rx_cnt_nxt = '0;
            w_to_cnt_nxt = '0;
            w_state_nxt  = ST_RX_WAIT;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + 1'b1;
            w_state_nxt    = ST_TX_START;
          end
        end
      end
      ST_RX_WAIT: begin
        w_to_cnt_nxt = r_to_cnt + 1'b1;
        // A completing byte takes priority over window expiry on the same cycle.
        if (w_rx_valid && !w_rx_frame_err) begin
          if (r_rx_cnt == c_NB_LAST) begin
            w_nonce_nxt       = {w_rx_data, r_asm};
            w_nonce_valid_nxt = 1'b1;
            w_state_nxt       = ST_IDLE;
          end else begin
            case (r_rx_cnt)
              2'd0:    w_asm_nxt[7:0]   = w_rx_data;
              2'd1:    w_asm_nxt[15:8]  = w_rx_data;
              default: w_asm_nxt[23:16] = w_rx_data;
            endcase
            w_rx_cnt_nxt = r_rx_cnt + 1'b1;
          end
        end else if (r_to_cnt == c_TO_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (r_state)
      ST_TX_START: txd = 1'b0;
      ST_TX_DATA:  txd = r_shift[0];
      default:     txd = 1'b1;
    endcase
  end

  assign work_ready  = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign nonce       = r_nonce;
  assign nonce_valid = r_nonce_valid;
  assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_icarus_work_sender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_icarus_work_sender : directed bench for the work sender            |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_icarus_work_sender;

  localparam int WB     = 64;
  localparam int CPB    = 10;
  localparam int BYTE_C = CPB * 10;
  localparam int FRAME  = WB * BYTE_C;   // 6400
  localparam int TO     = 600;           // sized to fit five reply frames

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [8*WB-1:0]   work_data = '0;
  logic              work_valid = 1'b0;
  logic              work_ready;
  logic              txd;
  logic              rxd = 1'b1;
  logic [31:0]       nonce;
  logic              nonce_valid;
  logic              timeout;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [8*WB-1:0] p1, p2, p3;

  always #5 clk = ~clk;

  icarus_work_sender #(
    .CLK_FREQ     (100000000),
    .BAUD         (115200),
    .CLKS_PER_BIT (CPB),
    .WORK_BYTES   (WB),
    .TIMEOUT_CLKS (TO)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .work_data   (work_data),
    .work_valid  (work_valid),
    .work_ready  (work_ready),
    .txd         (txd),
    .rxd         (rxd),
    .nonce       (nonce),
    .nonce_valid (nonce_valid),
    .timeout     (timeout),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*WB-1:0] make_pkt(input logic [7:0] mul, input logic [7:0] add);
    logic [8*WB-1:0] p;
    for (int i = 0; i < WB; i++) p[8*i +: 8] = 8'(i) * mul + add;
    return p;
  endfunction

  // Expected txd in cycle c (1-based) after the handshake edge.
  function automatic logic exp_txd(input logic [8*WB-1:0] pkt, input int c);
    int k, pos;
    k   = (c - 1) / BYTE_C;
    pos = ((c - 1) % BYTE_C) / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return pkt[8*k + pos - 1];
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1 after the handshake.
  task automatic handshake(input logic [8*WB-1:0] pkt);
    work_data  = pkt;
    work_valid = 1'b1;
    check("ready_before_hs", {31'd0, work_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    work_valid = 1'b0;
    check("busy_after_hs", {31'd0, busy}, 32'd1);
  endtask

  task automatic send_packet(input logic [8*WB-1:0] pkt);
    handshake(pkt);
    repeat (FRAME - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int n = 0; n < BYTE_C; n++) begin
      if (n % CPB == 0) rxd = fr[n/CPB];
      @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  // Last reply byte; the strobe lands at negedge 98, nonce_valid at 99.
  task automatic send_last_and_check(input logic [7:0] b, input logic [31:0] exp);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int n = 0; n < BYTE_C; n++) begin
      if (n % CPB == 0) rxd = fr[n/CPB];
      if (n == 98) begin
        check("nv_before", {31'd0, nonce_valid}, 32'd0);
        check("ready_before_nv", {31'd0, work_ready}, 32'd0);
      end
      if (n == 99) begin
        check("nv_pulse", {31'd0, nonce_valid}, 32'd1);
        check("ready_with_nv", {31'd0, work_ready}, 32'd1);
        check("busy_with_nv", {31'd0, busy}, 32'd0);
        check("nonce_value", nonce, exp);
        check("no_timeout_with_nv", {31'd0, timeout}, 32'd0);
      end
      @(negedge clk);
    end
    check("nv_one_cycle", {31'd0, nonce_valid}, 32'd0);
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_nonce);
    check({tag, "_txd"},   {31'd0, txd},         32'd1);
    check({tag, "_ready"}, {31'd0, work_ready},  32'd1);
    check({tag, "_busy"},  {31'd0, busy},        32'd0);
    check({tag, "_nonce"}, nonce,                exp_nonce);
    check({tag, "_nv"},    {31'd0, nonce_valid}, 32'd0);
    check({tag, "_to"},    {31'd0, timeout},     32'd0);
  endtask

  initial begin
    p1 = make_pkt(8'h1D, 8'h3C);
    p1[7:0] = 8'hA5;
    p2 = make_pkt(8'h53, 8'h07);
    p3 = make_pkt(8'hC1, 8'h9E);

    // 1. Reset state
    #1;
    check_idle("rst_async", 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("rst_release", 32'h0);

    // 2. Full packet serialization, bit-exact every cycle
    handshake(p1);
    for (int c = 1; c <= FRAME; c++) begin
      if (c == 3) work_data = ~p1;
      check("tx_p1_txd", {31'd0, txd}, {31'd0, exp_txd(p1, c)});
      check("tx_p1_ready", {31'd0, work_ready}, 32'd0);
      if (c < FRAME) @(negedge clk);
    end
    @(negedge clk);
    check("rxwait_txd", {31'd0, txd}, 32'd1);
    check("rxwait_busy", {31'd0, busy}, 32'd1);

    // 3. Nonce reply
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_last_and_check(8'h12, 32'h12345678);

    // 4. No reply (only a short glitch): timeout after exactly TO cycles
    send_packet(p2);
    repeat (100) @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (TO - 103) @(negedge clk);
    check("to_before", {31'd0, timeout}, 32'd0);
    check("to_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("to_pulse", {31'd0, timeout}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_ready", {31'd0, work_ready}, 32'd1);
    check("to_nonce_held", nonce, 32'h12345678);
    check("to_no_nv", {31'd0, nonce_valid}, 32'd0);
    @(negedge clk);
    check("to_one_cycle", {31'd0, timeout}, 32'd0);

    // 5. Glitch, framing error, then good bytes
    send_packet(p2);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_last_and_check(8'hDE, 32'hDEADBEEF);

    // 6. Echoes during TX and work_valid while busy are ignored
    handshake(p3);
    for (int c = 1; c <= FRAME; c++) begin
      if (c >= 100 && c < 400 && (c - 100) % CPB == 0) begin
        logic [9:0] fr;
        int         e;
        e  = c - 100;
        fr = {1'b1, 8'h11 * 8'(e / BYTE_C + 1), 1'b0};
        rxd = fr[(e % BYTE_C) / CPB];
      end
      if (c == 200) begin
        work_valid = 1'b1;
        work_data  = ~p3;
      end
      if (c == 220) work_valid = 1'b0;
      if (c == 210) begin
        check("busy_hold_busy", {31'd0, busy}, 32'd1);
        check("busy_hold_ready", {31'd0, work_ready}, 32'd0);
      end
      if (c % CPB == 5) check("tx_p3_txd", {31'd0, txd}, {31'd0, exp_txd(p3, c)});
      if (c < FRAME) @(negedge clk);
    end
    check("p3_end_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_last_and_check(8'h00, 32'h00000001);

    // 1b. Asynchronous reset mid-transfer, between clock edges
    handshake(p1);
    repeat (3) @(negedge clk);
    check("mid_start_bit", {31'd0, txd}, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("rst_mid", 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("rst_mid_release", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
